// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch queue: FSM states and the
// queue entry layout at default widths.
package fetch_pkg;

    localparam int DEF_PC_W    = 16;
    localparam int DEF_INSTR_W = 16;
    localparam int DEF_DEPTH   = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_PC_W-1:0]    pc;
        logic [DEF_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake: head instruction, its PC and queue occupancy.
interface fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
);

    logic                       instr_valid_o;
    logic                       instr_ready_i;
    logic [INSTR_W-1:0]         instr_o;
    logic [PC_W-1:0]            instr_pc_o;
    logic [$clog2(DEPTH+1)-1:0] count_o;

    modport master (
        output instr_valid_o,
        output instr_o,
        output instr_pc_o,
        output count_o,
        input  instr_ready_i
    );

    modport slave (
        input  instr_valid_o,
        input  instr_o,
        input  instr_pc_o,
        input  count_o,
        output instr_ready_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue storage: DEPTH-entry synchronous FIFO with flush,
// wrap-around pointers and an occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = DEF_DEPTH,
    parameter type entry_t = fetch_entry_t,
    localparam int CNT_W   = $clog2(DEPTH+1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  entry_t           wrData,
    output entry_t           rdData,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : gBadDepth
        $error("fetch_fifo: DEPTH must be a power of two, at least 2");
    end

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] rdPtr;
    logic [PTR_W-1:0] wrPtr;
    logic             doPush;
    logic             doPop;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign rdData = mem[rdPtr];

    // NOTE: the storage array is deliberately not reset; count alone decides
    // which slots hold meaningful data, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= wrData;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rdPtr <= '0;
            wrPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // A push offered at full without a matching pop would be silently lost.
    assert property (@(posedge clk) disable iff (rst) push |-> (!full || pop));
    assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, reads the combinational ROM and buffers
// PC-tagged instructions for decode, with start/branch redirect and flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [PC_W-1:0]    start_address_i,
    input  logic               branch_i,
    input  logic [PC_W-1:0]    branchloc_i,
    output logic [PC_W-1:0]    imem_addr_o,
    input  logic [INSTR_W-1:0] imem_data_i,
    fetch_queue_if.master      dec,
    output logic [PC_W-1:0]    pc
);

    localparam int CNT_W = $clog2(DEPTH+1);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } queueEntry_t;

    fetch_state_t     state;
    logic [PC_W-1:0]  fetchPc;
    logic             redirect;
    logic             push;
    logic             pop;
    logic             valid;
    logic             empty;
    logic             full;
    logic [CNT_W-1:0] count;
    queueEntry_t      tail;
    queueEntry_t      head;

    // Head valid comes from queue state only, never from instr_ready_i.
    assign valid    = !empty;
    assign pop      = valid && dec.instr_ready_i;
    assign redirect = start_i || (branch_i && state == RUN);
    assign push     = (state == RUN) && !redirect && (!full || pop);
    assign tail     = '{pc: fetchPc, instr: imem_data_i};

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (queueEntry_t)
    ) uFifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .flush  (redirect),
        .wrData (tail),
        .rdData (head),
        .empty  (empty),
        .full   (full),
        .count  (count)
    );

    // NOTE: non-blocking assignments so every register sees pre-edge values
    // regardless of the order the simulator evaluates processes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            fetchPc <= '0;
        end else if (start_i) begin
            state   <= RUN;
            fetchPc <= start_address_i;
        end else if (branch_i && state == RUN) begin
            fetchPc <= branchloc_i;
        end else if (push) begin
            fetchPc <= fetchPc + 1'b1;
        end
    end

    assign imem_addr_o       = fetchPc;
    assign pc                = fetchPc;
    assign dec.instr_valid_o = valid;
    assign dec.instr_o       = valid ? head.instr : '0;
    assign dec.instr_pc_o    = valid ? head.pc : '0;
    assign dec.count_o       = count;

    // IDLE is only reachable through reset, which always empties the queue.
    assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> empty);

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-level reference model predicts
// state and accepted instructions; a negedge monitor compares the DUT.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int PC_W    = 16;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;

    typedef struct {
        bit           valid;
        int           count;
        logic [15:0]  pc;
        fetch_entry_t head;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        startI = 1'b0;
    logic        branchI = 1'b0;
    logic [15:0] startAddr = '0;
    logic [15:0] branchLoc = '0;
    logic [15:0] imemAddr;
    logic [15:0] imemData;
    logic [15:0] pcOut;

    int nChecks = 0;
    int nPass   = 0;

    // Reference model: contents of the queue, fetch PC, run flag.
    fetch_entry_t modelQ[$];
    fetch_entry_t expQ[$];
    snap_t        snapQ[$];
    logic [15:0]  mPc = '0;
    bit           mRun = 1'b0;
    bit           known = 1'b0;

    fetch_queue_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) decIf ();

    fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .start_i         (startI),
        .start_address_i (startAddr),
        .branch_i        (branchI),
        .branchloc_i     (branchLoc),
        .imem_addr_o     (imemAddr),
        .imem_data_i     (imemData),
        .dec             (decIf),
        .pc              (pcOut)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'h9E37;
        return p ^ 16'hC3A5;
    endfunction

    assign imemData = rom(imemAddr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Drive one cycle of inputs, record the expected observable state and any
    // accepted instruction, then advance the model across the coming edge.
    task automatic cycle(input bit r, input bit s, input logic [15:0] sa,
                         input bit b, input logic [15:0] bl, input bit rdy);
        bit           hs;
        bit           wasFull;
        snap_t        sn;
        fetch_entry_t e;
        rst = r; startI = s; startAddr = sa; branchI = b; branchLoc = bl;
        decIf.instr_ready_i = rdy;
        if (known) begin
            sn.valid = (modelQ.size() != 0);
            sn.count = modelQ.size();
            sn.pc    = mPc;
            sn.head  = (modelQ.size() != 0) ? modelQ[0] : '0;
            snapQ.push_back(sn);
        end
        hs = known && (modelQ.size() != 0) && rdy;
        if (hs) expQ.push_back(modelQ[0]);
        wasFull = (modelQ.size() == DEPTH);
        if (r) begin
            mRun = 1'b0; mPc = '0; modelQ.delete(); known = 1'b1;
        end else if (!known) begin
            mRun = 1'b0;
        end else if (s) begin
            mRun = 1'b1; mPc = sa; modelQ.delete();
        end else if (b && mRun) begin
            mPc = bl; modelQ.delete();
        end else begin
            if (hs) void'(modelQ.pop_front());
            if (mRun && (!wasFull || hs)) begin
                e.pc = mPc; e.instr = rom(mPc);
                modelQ.push_back(e);
                mPc = mPc + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT against the model on every falling edge.
    initial begin : monitor
        snap_t        s;
        fetch_entry_t e;
        forever begin
            @(negedge clk);
            if (snapQ.size() != 0) begin
                s = snapQ.pop_front();
                check("instr_valid_o", 32'(decIf.instr_valid_o), 32'(s.valid));
                check("count_o", 32'(decIf.count_o), 32'(s.count));
                check("pc", 32'(pcOut), 32'(s.pc));
                check("imem_addr_o", 32'(imemAddr), 32'(s.pc));
                check("head pc", 32'(decIf.instr_pc_o), 32'(s.head.pc));
                check("head instr", 32'(decIf.instr_o), 32'(s.head.instr));
            end
            if (decIf.instr_valid_o === 1'b1 && decIf.instr_ready_i === 1'b1) begin
                if (expQ.size() == 0) begin
                    nChecks++;
                    $display("FAIL accept: got pc %0h expected no handshake at %0t",
                             decIf.instr_pc_o, $time);
                end else begin
                    e = expQ.pop_front();
                    check("accepted pc", 32'(decIf.instr_pc_o), 32'(e.pc));
                    check("accepted instr", 32'(decIf.instr_o), 32'(e.instr));
                end
            end
        end
    end

    initial begin : driver
        decIf.instr_ready_i = 1'b0;
        cycle(1, 0, 16'h0, 0, 16'h0, 0);
        cycle(1, 0, 16'h0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 0, 16'h0, 1);

        // Start at 0x0010, decode always ready.
        cycle(0, 1, 16'h0010, 0, 16'h0, 1);
        for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 0, 16'h0, 1);

        // Start at 0, stall decode until full, then drain and keep streaming.
        cycle(0, 1, 16'h0000, 0, 16'h0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 16'h0, 0, 16'h0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 16'h0, 0, 16'h0, 1);

        // Build up three entries, then branch to 0x0040.
        cycle(0, 1, 16'h0100, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 16'h0, 0, 16'h0, 0);
        cycle(0, 0, 16'h0, 1, 16'h0040, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 0, 16'h0, 1);

        // PC wrap from 0xFFFF to 0.
        cycle(0, 1, 16'hFFFE, 0, 16'h0, 1);
        for (int i = 0; i < 6; i++) cycle(0, 0, 16'h0, 0, 16'h0, 1);

        // Reset beats start and branch; branch in IDLE does nothing.
        cycle(1, 1, 16'h0055, 1, 16'h0066, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 16'h0, 1, 16'h0040, 1);

        cycle(0, 1, 16'h0200, 0, 16'h0, 1);
        for (int i = 0; i < 1500; i++) begin
            bit          r;
            bit          s;
            bit          b;
            bit          rdy;
            logic [15:0] sa;
            r   = ($urandom_range(199) == 0);
            s   = ($urandom_range(39) == 0);
            b   = ($urandom_range(14) == 0);
            rdy = ($urandom_range(9) < 7);
            sa  = ($urandom_range(3) == 0) ? (16'hFFFC + 16'($urandom_range(3))) : 16'($urandom);
            cycle(r, s, sa, b, 16'($urandom), rdy);
        end

        decIf.instr_ready_i = 1'b0;
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised successor to the single-PC `fetch` stage of the pipelined CPU.
- Owns the PC and reads the combinational instruction ROM.
- Buffers fetched instructions, tagged with their PC, in a DEPTH-entry prefetch queue.
- Presents them to decode over a valid/ready handshake.
- Adds start/branch redirect with queue flush, backpressure, and configurable PC width, instruction width and depth.

Parameters:
- PC_W, 16, width of the PC and of every address port.
- INSTR_W, 16, width of one instruction word from the ROM.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin fetching at start_address_i.
- start_address_i  in  PC_W  start PC.
- branch_i  in  1  redirect request from execute.
- branchloc_i  in  PC_W  branch target.
- imem_addr_o  out  PC_W  ROM address, equal to fetch_pc.
- imem_data_i  in  INSTR_W  ROM data for imem_addr_o, same cycle.
- instr_valid_o  out  1  queue head is valid.
- instr_ready_i  in  1  decode accepts the head.
- instr_o  out  INSTR_W  head instruction.
- instr_pc_o  out  PC_W  PC of the head instruction.
- count_o  out  $clog2(DEPTH+1)  queue occupancy.
- pc  out  PC_W  current fetch_pc, kept for existing debug wiring.

Behaviour:
- Reset (rst=1 at an edge) sets:
  - state=IDLE, fetch_pc=0, queue empty, count_o=0, instr_valid_o=0;
  - instr_o=0 and instr_pc_o=0 whenever instr_valid_o=0.
- Per-edge priority: rst > start_i > branch_i > normal operation.
- States:
  - IDLE: no pushes. start_i → RUN with fetch_pc<=start_address_i. branch_i ignored.
  - RUN: fetches each cycle. start_i re-enters RUN at the new address with a flush. rst → IDLE. There is no other exit.
- Push rule (RUN, no start/branch this edge):
  - push = !full || pop, where pop = instr_valid_o && instr_ready_i.
  - A push writes {fetch_pc, imem_data_i} at the tail, then fetch_pc <= fetch_pc+1.
  - The PC wraps modulo 2^PC_W, from all-ones to 0.
  - No push means fetch_pc holds.
- Pop:
  - The head advances when pop=1.
  - Simultaneous push and pop leaves count unchanged, including at full and at empty. At empty the pushed entry becomes visible next cycle; there is no bypass.
- Redirect (start_i or branch_i in RUN):
  - The whole queue is flushed: count=0, instr_valid_o=0 next cycle.
  - fetch_pc <= target. No push occurs that edge.
  - A handshake in the redirect cycle counts as accepted by decode; nothing further from the old stream is ever presented.
- Latency:
  - Redirect at edge E0 → ROM addressed with the target during E0..E1 → pushed at E1 → instr_valid_o=1 with instr_pc_o=target after E1 (2 edges).
  - Steady-state throughput is 1 instruction/cycle while decode is ready.
- Registered outputs: instr_valid_o, instr_o, instr_pc_o and count_o are driven from queue state only. No combinational path from instr_ready_i to them.
- imem_addr_o and pc: always equal fetch_pc, including in IDLE.
- count_o: ranges 0..DEPTH. full is count==DEPTH; empty is count==0.

Decomposition:
- fetch_pkg holds:
  - fetch_state_t enum {IDLE, RUN};
  - default localparams for PC_W/INSTR_W/DEPTH;
  - the queue entry struct {pc, instr}.
- Sub-module fetch_fifo: synchronous FIFO with push/pop/flush, DEPTH entries, wrap-around read/write pointers, count output.
- fetch_queue holds the PC, the FSM and the push/redirect logic.

Test Plan:
- Reset, then start_i=1 with start_address_i=0x0010, ready=1 → instr_valid_o rises 2 edges later; instr_pc_o = 0x0010, 0x0011, 0x0012… on consecutive cycles; instr_o equals the ROM contents at each PC.
- Start at 0x0000, ready=0 for 8 cycles → count_o climbs to 4 and holds, pc holds at 0x0004. Raising ready then drains 0x0000..0x0003 in order with no gap, and fetch resumes at 0x0004.
- Queue full with ready=1 → push and pop each cycle; count_o stays 4; the PC sequence has no skips or duplicates.
- branch_i=1 with branchloc_i=0x0040 while count_o=3 → instr_valid_o=0 next cycle, then instr_pc_o=0x0040 two edges after the branch; no old-stream PC is ever presented.
- Start at 0xFFFE (PC_W=16), ready=1 → instr_pc_o sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Mid-run rst=1 with branch_i=1 and start_i=1 in the same cycle → state IDLE, count_o=0, pc=0, instr_valid_o=0. branch_i while IDLE produces no fetch.
